mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator-side controller for the processor's 16-bit data memory.
- Accepts single load/store requests from the datapath over a valid/ready handshake and drives the memory's address, write_data, r_flag and w_flag pins with correct timing.
- Captures read_data after the memory's read latency and returns it on a valid/ready response channel.
- Sits between the control unit/datapath and the Memory block; the memory itself carries no handshake.

Parameters:
- ADDR_WIDTH, 16, width of request and memory address.
- DATA_WIDTH, 16, width of data words (signed two's complement).
- MEM_DEPTH, 16, number of implemented words; addresses >= MEM_DEPTH are errors.
- READ_LATENCY, 1, edges after the r_flag-sampling edge until read_data is valid (0 = combinational read, legal range 0..7).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  word address.
- req_wdata  in  DATA_WIDTH signed  store data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_WIDTH signed  load data (0 for stores and errors).
- rsp_err  out  1  address out of range; no memory access made.
- mem_address  out  ADDR_WIDTH  to memory address.
- mem_write_data  out  DATA_WIDTH signed  to memory write_data.
- mem_r_flag  out  1  to memory r_flag.
- mem_w_flag  out  1  to memory w_flag.
- mem_read_data  in  DATA_WIDTH signed  from memory read_data.
- txn_count  out  16  completed-response counter.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - All outputs 0 except req_ready, which is 1 once rst_n=1.
  - txn_count=0.
  - Reset mid-transaction aborts immediately: flags drop with rst_n low, and no response is produced.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready=1; all other handshake outputs 0.
  - On req_valid&req_ready at edge: latch req_addr/req_we/req_wdata.
  - If req_addr >= MEM_DEPTH -> RESP with rsp_err=1, rsp_rdata=0; no flag is ever asserted.
  - Otherwise -> ISSUE.
- ISSUE (exactly 1 cycle):
  - mem_address = latched addr.
  - mem_write_data = latched wdata (stores).
  - mem_w_flag = we, mem_r_flag = ~we; never both high.
  - Store -> RESP with rsp_rdata=0, rsp_err=0.
  - Load with READ_LATENCY=0: sample mem_read_data at this edge -> RESP.
  - Load with READ_LATENCY>0 -> WAIT with counter = READ_LATENCY-1.
- WAIT:
  - Flags 0; mem_address held stable.
  - Counter decrements each edge; when counter==0, sample mem_read_data into rsp_rdata -> RESP.
  - The sampling edge is edge READ_LATENCY after the ISSUE edge.
- RESP:
  - rsp_valid=1; rsp_rdata/rsp_err held stable until rsp_ready.
  - On rsp_valid&rsp_ready: txn_count += 1 (wraps 0xFFFF -> 0), then -> IDLE.
- req_ready=0 in every state except IDLE; no request is accepted while a response is pending (no back-to-back overlap).
- mem_address and mem_write_data hold their last values outside ISSUE/WAIT; both flags are 0 outside ISSUE.
- Latency, request accept edge to rsp_valid high:
  - store: 2 cycles.
  - load: 2+READ_LATENCY cycles.
  - error: 1 cycle.
- Data is passed unmodified; no sign or width conversion.
- All outputs are registered or decoded from the state register only; no combinational path from req_* or rsp_ready to outputs except the RESP->IDLE transition.

Decomposition:
- Shared package holds:
  - state enum (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3);
  - word width constant 16;
  - default MEM_DEPTH.
- No sub-module required. Optionally split a small latency counter, lat_counter (load/decrement/zero flag), if reused by other multi-cycle units.

Test Plan:
- Reset then store addr=3 data=-5 (0xFFFB):
  - mem_w_flag high exactly 1 cycle with mem_address=3, mem_write_data=0xFFFB, mem_r_flag=0;
  - rsp_valid 2 cycles after accept with rsp_err=0, rsp_rdata=0;
  - txn_count=1.
- Load addr=3, READ_LATENCY=1, memory model returns 0xFFFB:
  - mem_r_flag 1 cycle;
  - rsp_rdata=0xFFFB at 3 cycles after accept.
- Repeat the load with READ_LATENCY=0 and with READ_LATENCY=3: rsp_valid at 2 and 5 cycles respectively; data correct.
- Request addr=16 (MEM_DEPTH=16):
  - no flag asserted;
  - rsp_valid next cycle with rsp_err=1, rsp_rdata=0.
- Hold rsp_ready=0 for 4 cycles with req_valid=1 asserted throughout:
  - rsp_valid and data stable;
  - req_ready=0 during the hold;
  - second request accepted only after the response handshake.
- Assert rst_n=0 during WAIT of a load: flags and rsp_valid go 0 immediately, state IDLE, txn_count=0, no response after release. Also pre-load txn_count to 0xFFFF via 65535 transactions and check that the next completion wraps it to 0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the data-memory access unit: controller state
// encoding, the machine word width and the default number of implemented
// memory words.
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

    localparam int WORD_WIDTH        = 16;
    localparam int DEFAULT_MEM_DEPTH = 16;

    // Wide enough for READ_LATENCY-1 with READ_LATENCY up to 7.
    localparam int LAT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage : mem_access_unit_pkg

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Initiator-side controller for the 16-bit data memory. Accepts one load or
// store at a time over a valid/ready request channel, drives the memory pins
// (address, write data, r_flag, w_flag) for exactly one ISSUE cycle, waits out
// the memory read latency, and returns the result on a valid/ready response
// channel. Out-of-range addresses are answered with rsp_err and never reach
// the memory.
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         request handshake
//   req_we, req_addr, req_wdata store enable, word address, store data
//   rsp_valid/rsp_ready         response handshake
//   rsp_rdata, rsp_err          load data (0 for stores/errors), range error
//   mem_address, mem_write_data memory address / write data pins
//   mem_r_flag, mem_w_flag      memory read / write strobes
//   mem_read_data               memory read data
//   txn_count                   completed-response counter (wraps)
// -----------------------------------------------------------------------------
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = WORD_WIDTH,
    parameter int MEM_DEPTH    = DEFAULT_MEM_DEPTH,
    parameter int READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic signed [DATA_WIDTH-1:0] req_wdata,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic signed [DATA_WIDTH-1:0] rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_WIDTH-1:0]        mem_address,
    output logic signed [DATA_WIDTH-1:0] mem_write_data,
    output logic                         mem_r_flag,
    output logic                         mem_w_flag,
    input  logic signed [DATA_WIDTH-1:0] mem_read_data,
    output logic [15:0]                  txn_count
);

    // WAIT counts down from READ_LATENCY-1; unused when READ_LATENCY is 0.
    localparam logic [LAT_WIDTH-1:0] LAT_INIT =
        (READ_LATENCY > 0) ? LAT_WIDTH'(READ_LATENCY - 1) : '0;

    state_t               state;
    logic                 op_we;
    logic [LAT_WIDTH-1:0] lat_cnt;
    logic                 addr_ok;

    assign addr_ok = (req_addr < ADDR_WIDTH'(MEM_DEPTH));

    // Decoded from the state register only. req_ready is also gated by
    // rst_n so it stays low while the unit is held in reset.
    assign req_ready = rst_n && (state == IDLE);
    assign rsp_valid = (state == RESP);

    // NOTE: every register here, including the data-path holding registers,
    // is cleared by the async reset so the memory pins are defined from the
    // moment rst_n falls; all updates use non-blocking assignments so each
    // branch reads the pre-edge values of the other registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            op_we          <= 1'b0;
            lat_cnt        <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_r_flag     <= 1'b0;
            mem_w_flag     <= 1'b0;
            rsp_rdata      <= '0;
            rsp_err        <= 1'b0;
            txn_count      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_we     <= req_we;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        if (addr_ok) begin
                            mem_address <= req_addr;
                            if (req_we) begin
                                mem_write_data <= req_wdata;
                            end
                            // Exactly one strobe is raised for the ISSUE cycle.
                            mem_w_flag <= req_we;
                            mem_r_flag <= !req_we;
                            state      <= ISSUE;
                        end else begin
                            // Rejected without touching the memory pins.
                            rsp_err <= 1'b1;
                            state   <= RESP;
                        end
                    end
                end

                ISSUE: begin
                    mem_w_flag <= 1'b0;
                    mem_r_flag <= 1'b0;
                    if (op_we) begin
                        state <= RESP;
                    end else if (READ_LATENCY == 0) begin
                        // Combinational memory: data is valid alongside r_flag.
                        rsp_rdata <= mem_read_data;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= LAT_INIT;
                        state   <= WAIT;
                    end
                end

                WAIT: begin
                    if (lat_cnt == '0) begin
                        rsp_rdata <= mem_read_data;
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end

                RESP: begin
                    if (rsp_ready) begin
                        txn_count <= txn_count + 16'd1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule : mem_access_unit

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
// Three units share one clock and reset, built with READ_LATENCY 1, 0 and 3,
// each attached to its own behavioural memory. The memory returns a marker
// word outside its read-data window so a unit sampling on the wrong edge
// picks up the marker instead of the stored data.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int            NUM_DUT = 3;
    localparam logic [15:0]   JUNK    = 16'h5A5A;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;  // expected response data
        logic        err;    // expected range error
        int          lat;    // expected cycles from accept edge to rsp_valid
    } vec_t;

    logic clk;
    logic rst_n;

    logic               req_valid      [NUM_DUT];
    logic               req_ready      [NUM_DUT];
    logic               req_we         [NUM_DUT];
    logic [15:0]        req_addr       [NUM_DUT];
    logic signed [15:0] req_wdata      [NUM_DUT];
    logic               rsp_valid      [NUM_DUT];
    logic               rsp_ready      [NUM_DUT];
    logic signed [15:0] rsp_rdata      [NUM_DUT];
    logic               rsp_err        [NUM_DUT];
    logic [15:0]        mem_address    [NUM_DUT];
    logic signed [15:0] mem_write_data [NUM_DUT];
    logic               mem_r_flag     [NUM_DUT];
    logic               mem_w_flag     [NUM_DUT];
    logic signed [15:0] mem_read_data  [NUM_DUT];
    logic [15:0]        txn_count      [NUM_DUT];

    int          n_vec;
    int          n_bad;
    vec_t        sb [$];
    logic [15:0] exp_count [NUM_DUT];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NUM_DUT; g++) begin : g_dut
        localparam int RL = (g == 0) ? 1 : ((g == 1) ? 0 : 3);

        logic [15:0] mem  [16];
        logic [15:0] pipe [8];

        mem_access_unit #(.READ_LATENCY(RL)) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .req_valid     (req_valid[g]),
            .req_ready     (req_ready[g]),
            .req_we        (req_we[g]),
            .req_addr      (req_addr[g]),
            .req_wdata     (req_wdata[g]),
            .rsp_valid     (rsp_valid[g]),
            .rsp_ready     (rsp_ready[g]),
            .rsp_rdata     (rsp_rdata[g]),
            .rsp_err       (rsp_err[g]),
            .mem_address   (mem_address[g]),
            .mem_write_data(mem_write_data[g]),
            .mem_r_flag    (mem_r_flag[g]),
            .mem_w_flag    (mem_w_flag[g]),
            .mem_read_data (mem_read_data[g]),
            .txn_count     (txn_count[g])
        );

        initial begin
            for (int j = 0; j < 16; j++) mem[j] = '0;
            for (int j = 0; j < 8; j++) pipe[j] = JUNK;
        end

        // Memory samples the flags at the clock edge; a read launched at that
        // edge is valid RL edges later, for one cycle only.
        always @(posedge clk) begin
            if (mem_w_flag[g]) mem[mem_address[g][3:0]] <= mem_write_data[g];
            pipe[0] <= mem_r_flag[g] ? mem[mem_address[g][3:0]] : JUNK;
            for (int j = 1; j < 8; j++) pipe[j] <= pipe[j-1];
        end

        if (RL == 0) begin : g_comb
            assign mem_read_data[g] = mem_r_flag[g] ? mem[mem_address[g][3:0]] : JUNK;
        end else begin : g_pipe
            assign mem_read_data[g] = pipe[RL-1];
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete transaction on unit k. With keep_valid set, req_valid stays
    // high until the response handshake to show nothing else is accepted.
    task automatic run_txn(input int k, input vec_t v, input int hold, input bit keep_valid);
        int   n;
        int   wcnt;
        int   rcnt;
        bit   got;
        vec_t e;
        @(negedge clk);
        req_we[k]    = v.we;
        req_addr[k]  = v.addr;
        req_wdata[k] = v.wdata;
        req_valid[k] = 1'b1;
        check("req_ready_idle", 16'(req_ready[k]), 16'd1);
        @(posedge clk);
        sb.push_back(v);
        n = 0; wcnt = 0; rcnt = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (!keep_valid) req_valid[k] = 1'b0;
            if (mem_w_flag[k]) begin
                wcnt++;
                check("w_addr", mem_address[k], v.addr);
                check("w_data", mem_write_data[k], v.wdata);
            end
            if (mem_r_flag[k]) begin
                rcnt++;
                check("r_addr", mem_address[k], v.addr);
            end
            if (rsp_valid[k]) got = 1'b1;
        end
        check("rsp_latency", 16'(n), 16'(v.lat));
        check("w_flag_cycles", 16'(wcnt), 16'(v.we && !v.err));
        check("r_flag_cycles", 16'(rcnt), 16'(!v.we && !v.err));
        e = sb.pop_front();
        check("rsp_rdata", rsp_rdata[k], e.rdata);
        check("rsp_err", 16'(rsp_err[k]), 16'(e.err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_rsp_valid", 16'(rsp_valid[k]), 16'd1);
            check("hold_rsp_rdata", rsp_rdata[k], e.rdata);
            check("hold_rsp_err", 16'(rsp_err[k]), 16'(e.err));
            check("hold_req_ready", 16'(req_ready[k]), 16'd0);
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        exp_count[k] = exp_count[k] + 16'd1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        check("rsp_valid_drop", 16'(rsp_valid[k]), 16'd0);
        check("txn_count", txn_count[k], exp_count[k]);
        if (keep_valid) check("req_ready_after_hs", 16'(req_ready[k]), 16'd1);
        req_valid[k] = 1'b0;
    endtask

    vec_t tbl [9];
    vec_t v;

    initial begin
        n_vec = 0;
        n_bad = 0;
        for (int k = 0; k < NUM_DUT; k++) begin
            req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
            req_wdata[k] = '0;   rsp_ready[k] = 1'b0; exp_count[k] = '0;
        end

        //          we    addr      wdata     rdata     err   lat
        tbl[0] = '{1'b1, 16'd3,    16'hFFFB, 16'h0000, 1'b0, 2};
        tbl[1] = '{1'b0, 16'd3,    16'h0000, 16'hFFFB, 1'b0, 3};
        tbl[2] = '{1'b1, 16'd15,   16'h7FFF, 16'h0000, 1'b0, 2};
        tbl[3] = '{1'b0, 16'd15,   16'h0000, 16'h7FFF, 1'b0, 3};
        tbl[4] = '{1'b1, 16'd0,    16'h8000, 16'h0000, 1'b0, 2};
        tbl[5] = '{1'b0, 16'd16,   16'h0000, 16'h0000, 1'b1, 1};
        tbl[6] = '{1'b1, 16'hFFFF, 16'h1234, 16'h0000, 1'b1, 1};
        tbl[7] = '{1'b0, 16'd0,    16'h0000, 16'h8000, 1'b0, 3};
        tbl[8] = '{1'b0, 16'd5,    16'h0000, 16'h0000, 1'b0, 3};

        // Reset values.
        rst_n = 1'b0;
        #2;
        check("rst_req_ready", 16'(req_ready[0]), 16'd0);
        check("rst_rsp_valid", 16'(rsp_valid[0]), 16'd0);
        check("rst_flags", 16'({mem_r_flag[0], mem_w_flag[0]}), 16'd0);
        check("rst_mem_address", mem_address[0], 16'd0);
        check("rst_txn_count", txn_count[0], 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("release_req_ready", 16'(req_ready[0]), 16'd1);

        // Main table on the READ_LATENCY=1 unit.
        for (int i = 0; i < 9; i++) run_txn(0, tbl[i], 0, 1'b0);

        // Same store/load on the READ_LATENCY=0 and =3 units.
        run_txn(1, tbl[0], 0, 1'b0);
        v = tbl[1]; v.lat = 2;
        run_txn(1, v, 0, 1'b0);
        run_txn(2, tbl[0], 0, 1'b0);
        v = tbl[1]; v.lat = 5;
        run_txn(2, v, 0, 1'b0);

        // Response back-pressure with a request waiting the whole time.
        run_txn(0, tbl[3], 4, 1'b1);
        run_txn(0, tbl[1], 0, 1'b0);

        // Reset during WAIT of a READ_LATENCY=3 load.
        @(negedge clk);
        req_we[2] = 1'b0; req_addr[2] = 16'd3; req_valid[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid[2] = 1'b0;
        check("pre_rst_r_flag", 16'(mem_r_flag[2]), 16'd1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_flags", 16'({mem_r_flag[2], mem_w_flag[2]}), 16'd0);
        check("midrst_rsp_valid", 16'(rsp_valid[2]), 16'd0);
        check("midrst_txn_count", txn_count[2], 16'd0);
        check("midrst_req_ready", 16'(req_ready[2]), 16'd0);
        for (int k = 0; k < NUM_DUT; k++) exp_count[k] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_idle", 16'(req_ready[2]), 16'd1);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (rsp_valid[2] || mem_r_flag[2] || mem_w_flag[2]) seen = 1'b1;
            end
            check("no_rsp_after_rst", 16'(seen), 16'd0);
        end

        // Counter wrap: run error transactions back to back up to 0xFFFF.
        begin
            bit reached = 1'b0;
            @(negedge clk);
            req_we[0] = 1'b0; req_addr[0] = 16'd16; req_valid[0] = 1'b1;
            rsp_ready[0] = 1'b1;
            for (int i = 0; i < 140000 && !reached; i++) begin
                @(negedge clk);
                if (txn_count[0] == 16'hFFFF) reached = 1'b1;
            end
            req_valid[0] = 1'b0;
            rsp_ready[0] = 1'b0;
            check("bulk_reached_ffff", 16'(reached), 16'd1);
            exp_count[0] = 16'hFFFF;
        end
        run_txn(0, tbl[2], 0, 1'b0);
        check("txn_count_wrapped", txn_count[0], 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_mem_access_unit
